ram_arbiter: RTL and testbench

//  Shares the single-port 32-bit word RAM between the core's instruction-fetch

---
 rtl/ram_arbiter.sv | 114 +++++++++++
 tb/tb_ram_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port word RAM between fetch (I) and load/store (D).
// Reads return one cycle after grant; byte-enable writes use a two-cycle read-modify-write.
`timescale 1ns/1ps
module ram_arbiter #(
  parameter int unsigned AW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          ram_wren,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  localparam int unsigned NB = 4;
  localparam logic RR_I = 1'b0;
  localparam logic RR_D = 1'b1;

  typedef enum logic [1:0] {IDLE, RD, MERGE} state_t;

  state_t        state;
  logic          rr_last;
  logic [AW-1:0] rmw_addr;
  logic [31:0]   rmw_wdata;
  logic [3:0]    rmw_be;
  logic          d_partial;
  logic          d_full;

  assign d_partial = (d_be != 4'h0) && (d_be != 4'hF);
  assign d_full    = (d_be == 4'hF);

  // Read data is never held; consumers qualify it with their own rvalid.
  assign i_rdata = ram_rdata;
  assign d_rdata = ram_rdata;

  // Grant decision: the side that did not win last time takes a conflict.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n && (state != MERGE)) begin
      if (i_req && d_req) begin
        if (rr_last == RR_D) i_gnt = 1'b1;
        else                 d_gnt = 1'b1;
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
  end

  // RAM drive: merge cycle writes back the latched bytes over the old word.
  always_comb begin
    ram_wren  = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (state == MERGE) begin
      ram_wren = 1'b1;
      ram_addr = rmw_addr;
      for (int unsigned b = 0; b < NB; b++) begin
        ram_wdata[8*b +: 8] = rmw_be[b] ? rmw_wdata[8*b +: 8] : ram_rdata[8*b +: 8];
      end
    end else if (i_gnt) begin
      ram_addr = i_addr;
    end else if (d_gnt) begin
      ram_addr = d_addr;
      if (d_we && d_full) begin
        ram_wren  = 1'b1;
        ram_wdata = d_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_last   <= RR_D;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      rmw_addr  <= '0;
      rmw_wdata <= '0;
      rmw_be    <= '0;
    end else begin
      i_rvalid <= i_gnt;
      d_rvalid <= d_gnt && !d_we;

      if (i_gnt)      rr_last <= RR_I;
      else if (d_gnt) rr_last <= RR_D;

      if (d_gnt && d_we && d_partial) begin
        rmw_addr  <= d_addr;
        rmw_wdata <= d_wdata;
        rmw_be    <= d_be;
      end

      if (i_gnt || (d_gnt && !d_we))      state <= RD;
      else if (d_gnt && d_we && d_partial) state <= MERGE;
      else                                 state <= IDLE;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: behavioural RAM plus read-data scoreboard per port.
`timescale 1ns/1ps
module tb_ram_arbiter;

  localparam int unsigned AW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt, i_rvalid;
  logic [31:0]   i_rdata;
  logic          d_req, d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt, d_rvalid;
  logic [31:0]   d_rdata;
  logic          ram_wren;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  logic [31:0] mem [0:127];
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  int tests = 0;
  int fails = 0;
  int wren_cnt = 0;

  ram_arbiter #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM, registered read, read-before-write.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
  endtask

  // Monitor: pops expected read data whenever a port presents rvalid.
  always @(negedge clk) begin
    if (ram_wren) wren_cnt++;
    check("gnt_onehot", 32'(i_gnt & d_gnt), 32'h0);
    check("rvalid_onehot", 32'(i_rvalid & d_rvalid), 32'h0);
    if (i_rvalid) begin
      if (iq.size() == 0) begin
        tests++; fails++;
        $display("FAIL i_rvalid_unexpected: got 1 expected 0 at %0t", $time);
      end else check("i_rdata", i_rdata, iq.pop_front());
    end
    if (d_rvalid) begin
      if (dq.size() == 0) begin
        tests++; fails++;
        $display("FAIL d_rvalid_unexpected: got 1 expected 0 at %0t", $time);
      end else check("d_rdata", d_rdata, dq.pop_front());
    end
  end

  initial begin
    int c0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h5A00_0000 | 32'(i);
    rst_n = 1'b0; idle_reqs();
    i_addr = '0; d_addr = '0; d_wdata = '0;
    i_req = 1'b1;
    repeat (2) step();
    check("rst_i_gnt", 32'(i_gnt), 32'h0);
    check("rst_ram_wren", 32'(ram_wren), 32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_rvalids", 32'({i_rvalid, d_rvalid}), 32'h0);
    idle_reqs();
    rst_n = 1'b1;
    step();

    // Conflict: I wins first after reset, then alternating.
    i_req = 1'b1; i_addr = 7'd2; d_req = 1'b1; d_we = 1'b0; d_addr = 7'd4;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_i_gnt", 32'(i_gnt), 32'((k % 2) == 0));
      check("rr_d_gnt", 32'(d_gnt), 32'((k % 2) == 1));
      if (i_gnt) iq.push_back(32'h5A00_0002);
      if (d_gnt) dq.push_back(32'h5A00_0004);
      step();
    end
    idle_reqs(); repeat (2) step();

    // Back-to-back fetches of addresses 0..3.
    i_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_addr = 7'(k);
      @(negedge clk);
      check("fetch_gnt", 32'(i_gnt), 32'h1);
      check("fetch_ram_addr", 32'(ram_addr), 32'(k));
      if (i_gnt) iq.push_back(32'h5A00_0000 + 32'(k));
      step();
    end
    idle_reqs(); repeat (2) step();

    // Full write then partial RMW on word 5.
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 7'd5; d_wdata = 32'h1122_3344;
    @(negedge clk);
    check("fw_d_gnt", 32'(d_gnt), 32'h1);
    check("fw_ram_wren", 32'(ram_wren), 32'h1);
    step();
    d_be = 4'b0101; d_wdata = 32'hAABB_CCDD;
    @(negedge clk);
    check("pw_d_gnt", 32'(d_gnt), 32'h1);
    check("pw_read_cycle_wren", 32'(ram_wren), 32'h0);
    step();
    idle_reqs(); i_req = 1'b1; i_addr = 7'd1;
    @(negedge clk);
    check("merge_i_gnt", 32'(i_gnt), 32'h0);
    check("merge_ram_wren", 32'(ram_wren), 32'h1);
    check("merge_ram_addr", 32'(ram_addr), 32'h5);
    check("merge_ram_wdata", ram_wdata, 32'h11BB_33DD);
    step();
    @(negedge clk);
    check("post_merge_i_gnt", 32'(i_gnt), 32'h1);
    if (i_gnt) iq.push_back(32'h5A00_0001);
    step();
    idle_reqs(); d_req = 1'b1; d_addr = 7'd5;
    @(negedge clk);
    if (d_gnt) dq.push_back(32'h11BB_33DD);
    step();
    idle_reqs(); repeat (2) step();
    check("mem5", mem[5], 32'h11BB_33DD);

    // Full write to the top address, then read back.
    c0 = wren_cnt;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 7'd127; d_wdata = 32'hDEAD_BEEF;
    step();
    idle_reqs(); repeat (3) step();
    check("top_wren_cycles", 32'(wren_cnt - c0), 32'h1);
    d_req = 1'b1; d_addr = 7'd127;
    @(negedge clk);
    if (d_gnt) dq.push_back(32'hDEAD_BEEF);
    step();
    idle_reqs(); repeat (2) step();

    // Write with no byte enables is a granted no-op.
    c0 = wren_cnt;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h0; d_addr = 7'd9; d_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("be0_d_gnt", 32'(d_gnt), 32'h1);
    check("be0_ram_wren", 32'(ram_wren), 32'h0);
    step();
    idle_reqs();
    @(negedge clk);
    check("be0_d_rvalid", 32'(d_rvalid), 32'h0);
    repeat (2) step();
    check("be0_wren_cycles", 32'(wren_cnt - c0), 32'h0);
    check("mem9", mem[9], 32'h5A00_0009);

    // Reset asserted during the merge cycle abandons the write.
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 7'd20; d_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rmw_rst_d_gnt", 32'(d_gnt), 32'h1);
    step();
    idle_reqs(); i_req = 1'b1; i_addr = 7'd3;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_gnts", 32'({i_gnt, d_gnt}), 32'h0);
    check("midrst_rvalids", 32'({i_rvalid, d_rvalid}), 32'h0);
    check("midrst_ram_wren", 32'(ram_wren), 32'h0);
    check("midrst_ram_addr", 32'(ram_addr), 32'h0);
    check("midrst_ram_wdata", ram_wdata, 32'h0);
    repeat (2) step();
    idle_reqs();
    rst_n = 1'b1;
    step();
    check("mem20_after_rst", mem[20], 32'h5A00_0014);
    d_req = 1'b1; d_we = 1'b0; d_addr = 7'd20;
    @(negedge clk);
    if (d_gnt) dq.push_back(32'h5A00_0014);
    step();
    idle_reqs(); repeat (3) step();

    check("iq_drained", 32'(iq.size()), 32'h0);
    check("dq_drained", 32'(dq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
